// File: rtl/vram_arb_pkg.sv
// Shared constants and enums for the VRAM port arbiter.
// The optional fairness feature is controlled by the VRAM_FAIRNESS_EN macro.
package vram_arb_pkg;
  localparam int VRAM_WORDS = 600;
  localparam int CTRL_ADDR  = VRAM_WORDS;

  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_AVL} owner_t;
  typedef enum logic [1:0] {IDLE, ISSUE, DATA, DONE} avl_state_t;
endpackage

// File: rtl/vram_fair_counter.sv
// Counts consecutive display grants while an Avalon request waits.
// Only instantiated when VRAM_FAIRNESS_EN is defined.
module vram_fair_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic inc,
  input  logic clr,
  output logic hit
);
  import vram_arb_pkg::*;

  logic [2:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != 3'd7)) begin
      count_reg <= count_reg + 3'd1;
    end
  end

  assign hit = (count_reg >= 3'(LIMIT));
endmodule

// File: rtl/vram_port_arbiter.sv
// Shares the single-port character VRAM between the display fetch and Avalon-MM,
// and owns the text-mode control register. Define VRAM_FAIRNESS_EN for bounded Avalon stall.
module vram_port_arbiter #(
  parameter int VRAM_WORDS = vram_arb_pkg::VRAM_WORDS,
  parameter int FAIR_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        AVL_READ,
  input  logic        AVL_WRITE,
  input  logic        AVL_CS,
  input  logic [3:0]  AVL_BYTE_EN,
  input  logic [11:0] AVL_ADDR,
  input  logic [31:0] AVL_WRITEDATA,
  output logic [31:0] AVL_READDATA,
  output logic        AVL_WAITREQUEST,
  input  logic        DISP_REQ,
  input  logic [9:0]  DISP_ADDR,
  output logic [31:0] DISP_DATA,
  output logic        DISP_VALID,
  output logic        DISP_OVERRUN,
  output logic [9:0]  RAM_ADDR,
  output logic [31:0] RAM_WDATA,
  output logic [3:0]  RAM_BE,
  output logic        RAM_WE,
  input  logic [31:0] RAM_RDATA,
  output logic [31:0] CTRL_REG
);
  import vram_arb_pkg::*;

  localparam logic [11:0] CTRL_WORD = 12'(VRAM_WORDS);

  avl_state_t  state_reg, state_next;
  owner_t      issue_tag_reg, data_tag_reg;
  logic        pend_valid_reg;
  logic [9:0]  pend_addr_reg;
  logic        overrun_reg;
  logic [9:0]  ram_addr_reg;
  logic [31:0] ram_wdata_reg;
  logic [3:0]  ram_be_reg;
  logic        ram_we_reg;
  logic [31:0] disp_data_reg;
  logic        disp_valid_reg;
  logic [31:0] avl_rdata_reg;
  logic [7:0]  ctrl_bytes_reg [4];

  logic        avl_req, avl_waiting, addr_is_ram, addr_is_ctrl;
  logic        disp_grant, avl_grant, avl_force, fair_hit;
  logic [9:0]  disp_grant_addr;

  assign avl_req      = AVL_CS & (AVL_READ | AVL_WRITE);
  assign avl_waiting  = avl_req & (state_reg == IDLE);
  assign addr_is_ram  = (AVL_ADDR < CTRL_WORD);
  assign addr_is_ctrl = (AVL_ADDR == CTRL_WORD);

`ifdef VRAM_FAIRNESS_EN
  vram_fair_counter #(.LIMIT(FAIR_LIMIT)) u_fair (
    .clk  (CLK),
    .srst (RESET),
    .inc  (disp_grant & avl_waiting),
    .clr  (avl_grant | ~avl_waiting),
    .hit  (fair_hit)
  );
`else
  assign fair_hit = 1'b0;
`endif

  // The display wins the slot unless the fairness limit forces the waiting Avalon access.
  assign avl_force       = avl_waiting & fair_hit;
  assign disp_grant      = (pend_valid_reg | DISP_REQ) & ~avl_force;
  assign avl_grant       = avl_waiting & ~disp_grant;
  assign disp_grant_addr = pend_valid_reg ? pend_addr_reg : DISP_ADDR;

  // Writes and non-RAM accesses complete the cycle after the grant, so only RAM reads
  // pass through ISSUE/DATA while the read data comes back.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (avl_grant) state_next = (AVL_WRITE || !addr_is_ram) ? DONE : ISSUE;
      ISSUE:   state_next = DATA;
      DATA:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg      <= IDLE;
      pend_valid_reg <= 1'b0;
      pend_addr_reg  <= '0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (DISP_REQ && pend_valid_reg) overrun_reg <= 1'b1;
      if (disp_grant && pend_valid_reg) begin
        pend_valid_reg <= 1'b0;
      end else if (DISP_REQ && !pend_valid_reg && !disp_grant) begin
        pend_valid_reg <= 1'b1;
        pend_addr_reg  <= DISP_ADDR;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
      ram_be_reg    <= '0;
      ram_we_reg    <= 1'b0;
      issue_tag_reg <= OWN_NONE;
    end else begin
      ram_we_reg    <= 1'b0;
      ram_be_reg    <= '0;
      issue_tag_reg <= OWN_NONE;
      if (disp_grant) begin
        ram_addr_reg  <= disp_grant_addr;
        issue_tag_reg <= OWN_DISP;
      end else if (avl_grant && addr_is_ram) begin
        ram_addr_reg  <= AVL_ADDR[9:0];
        ram_wdata_reg <= AVL_WRITEDATA;
        ram_be_reg    <= AVL_WRITE ? AVL_BYTE_EN : 4'b0000;
        ram_we_reg    <= AVL_WRITE;
        issue_tag_reg <= OWN_AVL;
      end
    end
  end

  // The tag follows its access one stage so returning RAM data reaches only its owner.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_tag_reg   <= OWN_NONE;
      disp_valid_reg <= 1'b0;
      disp_data_reg  <= '0;
      avl_rdata_reg  <= '0;
    end else begin
      data_tag_reg   <= issue_tag_reg;
      disp_valid_reg <= (data_tag_reg == OWN_DISP);
      if (data_tag_reg == OWN_DISP) disp_data_reg <= RAM_RDATA;
      if ((state_reg == DATA) && (data_tag_reg == OWN_AVL)) begin
        avl_rdata_reg <= RAM_RDATA;
      end else if (avl_grant && !AVL_WRITE && !addr_is_ram) begin
        avl_rdata_reg <= addr_is_ctrl ? CTRL_REG : 32'h0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ctrl_byte
      always_ff @(posedge CLK) begin
        if (RESET) begin
          ctrl_bytes_reg[gi] <= '0;
        end else if (avl_grant && AVL_WRITE && addr_is_ctrl && AVL_BYTE_EN[gi]) begin
          ctrl_bytes_reg[gi] <= AVL_WRITEDATA[gi*8 +: 8];
        end
      end
      assign CTRL_REG[gi*8 +: 8] = ctrl_bytes_reg[gi];
    end
  endgenerate

  assign AVL_WAITREQUEST = RESET | (avl_req & (state_reg != DONE));
  assign AVL_READDATA    = avl_rdata_reg;
  assign DISP_DATA       = disp_data_reg;
  assign DISP_VALID      = disp_valid_reg;
  assign DISP_OVERRUN    = overrun_reg;
  assign RAM_ADDR        = ram_addr_reg;
  assign RAM_WDATA       = ram_wdata_reg;
  assign RAM_BE          = ram_be_reg;
  assign RAM_WE          = ram_we_reg;
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Scoreboard bench for vram_port_arbiter: directed Avalon and display traffic against
// a registered-read RAM model; a negedge monitor checks every completion and its cycle.
module tb_vram_port_arbiter;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        AVL_READ, AVL_WRITE, AVL_CS;
  logic [3:0]  AVL_BYTE_EN;
  logic [11:0] AVL_ADDR;
  logic [31:0] AVL_WRITEDATA, AVL_READDATA;
  logic        AVL_WAITREQUEST;
  logic        DISP_REQ = 1'b0;
  logic [9:0]  DISP_ADDR = '0;
  logic [31:0] DISP_DATA;
  logic        DISP_VALID, DISP_OVERRUN;
  logic [9:0]  RAM_ADDR;
  logic [31:0] RAM_WDATA, RAM_RDATA, CTRL_REG;
  logic [3:0]  RAM_BE;
  logic        RAM_WE;

  vram_port_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .AVL_WAITREQUEST(AVL_WAITREQUEST),
    .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR), .DISP_DATA(DISP_DATA),
    .DISP_VALID(DISP_VALID), .DISP_OVERRUN(DISP_OVERRUN),
    .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA), .RAM_BE(RAM_BE), .RAM_WE(RAM_WE),
    .RAM_RDATA(RAM_RDATA), .CTRL_REG(CTRL_REG)
  );

  initial forever #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // RAM model: byte-enabled write, one-cycle registered read.
  logic        mem_clear = 1'b1;
  logic [31:0] mem [1024];
  always @(posedge CLK) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (RAM_WE) begin
      for (int b = 0; b < 4; b++)
        if (RAM_BE[b]) mem[RAM_ADDR][b*8 +: 8] <= RAM_WDATA[b*8 +: 8];
    end
    RAM_RDATA <= mem[RAM_ADDR];
  end

  typedef struct { logic wr; logic [11:0] addr; logic [31:0] data; logic [3:0] be; int start; } cmd_t;
  typedef struct { logic wr; logic [31:0] data; int cyc; } avl_exp_t;
  typedef struct { logic [31:0] data; int cyc; } disp_exp_t;

  cmd_t      cmd_q[$];
  avl_exp_t  avl_q[$];
  disp_exp_t disp_q[$];

  int   total = 0;
  int   bad = 0;
  int   done_count = 0;
  int   taken_count = 0;
  logic avl_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Avalon master agent: launches queued commands and drops strobes after completion.
  initial begin
    cmd_t c;
    AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0; AVL_ADDR = '0; AVL_WRITEDATA = '0; AVL_BYTE_EN = '0;
    forever begin
      @(posedge CLK); #2;
      if (avl_busy && (done_count != taken_count)) begin
        taken_count = done_count;
        avl_busy = 1'b0;
        AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0;
      end
      if (!avl_busy && (cmd_q.size() > 0) && (cmd_q[0].start <= cyc)) begin
        c = cmd_q.pop_front();
        AVL_CS = 1; AVL_READ = !c.wr; AVL_WRITE = c.wr;
        AVL_ADDR = c.addr; AVL_WRITEDATA = c.data; AVL_BYTE_EN = c.be;
        avl_busy = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a display word or an Avalon completion.
  initial begin
    disp_exp_t de;
    avl_exp_t  ae;
    forever begin
      @(negedge CLK);
      if (DISP_VALID) begin
        if (disp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL disp_unexpected: got data %h at cycle %0d expected no strobe", DISP_DATA, cyc);
        end else begin
          de = disp_q.pop_front();
          $display("disp  cyc=%0d data=%h", cyc, DISP_DATA);
          check("disp_data", DISP_DATA, de.data);
          check("disp_cycle", 32'(cyc), 32'(de.cyc));
        end
      end
      if (AVL_CS && (AVL_READ || AVL_WRITE) && !AVL_WAITREQUEST) begin
        done_count++;
        if (avl_q.size() == 0) begin
          total++; bad++;
          $display("FAIL avl_unexpected: completion at cycle %0d expected none", cyc);
        end else begin
          ae = avl_q.pop_front();
          $display("avl %s cyc=%0d addr=%0d data=%h", ae.wr ? "wr" : "rd", cyc, AVL_ADDR,
                   ae.wr ? AVL_WRITEDATA : AVL_READDATA);
          check("avl_cycle", 32'(cyc), 32'(ae.cyc));
          if (!ae.wr) check("avl_rdata", AVL_READDATA, ae.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic avl(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                     input logic [3:0] be, input logic [31:0] exp_data, input int lat);
    cmd_q.push_back('{wr, addr, data, be, cyc});
    avl_q.push_back('{wr, exp_data, cyc + lat});
  endtask

  task automatic disp(input logic [9:0] addr, input logic [31:0] exp_data);
    DISP_REQ = 1'b1; DISP_ADDR = addr;
    disp_q.push_back('{exp_data, cyc + 3});
    tick();
    DISP_REQ = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((avl_busy || cmd_q.size() > 0 || avl_q.size() > 0 || disp_q.size() > 0) && n < 40) begin
      tick(); n++;
    end
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_waitreq", 32'(AVL_WAITREQUEST), 32'd1);
    check("rst_ram_we", 32'(RAM_WE), 32'd0);
    check("rst_disp_valid", 32'(DISP_VALID), 32'd0);
    check("rst_overrun", 32'(DISP_OVERRUN), 32'd0);
    check("rst_ctrl", CTRL_REG, 32'h0);
    check("rst_rdata", AVL_READDATA, 32'h0);
    tick();
    RESET = 1'b0; mem_clear = 1'b0;
    tick();

    // RAM writes, display fetch and Avalon read-back
    avl(1, 12'd10, 32'h41424344, 4'hF, '0, 1);            wait_idle("wr10");
    disp(10'd10, 32'h41424344);                           wait_idle("disp10");
    avl(1, 12'd5, 32'hDEADBEEF, 4'b0101, '0, 1);          wait_idle("wr5");
    avl(0, 12'd5, '0, 4'h0, 32'h00AD00EF, 3);             wait_idle("rd5");
    avl(1, 12'd5, 32'hFFFFFFFF, 4'b0000, '0, 1);          wait_idle("wr5_be0");
    avl(0, 12'd5, '0, 4'h0, 32'h00AD00EF, 3);             wait_idle("rd5_again");
    avl(1, 12'd599, 32'hCAFEF00D, 4'hF, '0, 1);           wait_idle("wr599");
    avl(0, 12'd599, '0, 4'h0, 32'hCAFEF00D, 3);           wait_idle("rd599");

    // Control register and out-of-range addresses
    avl(1, 12'd600, 32'h01234567, 4'hF, '0, 1);           wait_idle("wr_ctrl");
    @(negedge CLK); check("ctrl_full", CTRL_REG, 32'h01234567); tick();
    avl(1, 12'd601, 32'hFFFFFFFF, 4'hF, '0, 1);           wait_idle("wr601");
    @(negedge CLK); check("ctrl_after_601", CTRL_REG, 32'h01234567); tick();
    avl(0, 12'd601, '0, 4'h0, 32'h0, 1);                  wait_idle("rd601");
    avl(1, 12'd600, 32'hAABBCCDD, 4'b0010, '0, 1);        wait_idle("wr_ctrl_be");
    avl(0, 12'd600, '0, 4'h0, 32'h0123CC67, 1);           wait_idle("rd_ctrl");
    avl(1, 12'h40A, 32'h99999999, 4'hF, '0, 1);           wait_idle("wr_alias");

    // Display and Avalon read in the same cycle
    avl(0, 12'd5, '0, 4'h0, 32'h00AD00EF, 4);
    disp(10'd10, 32'h41424344);                           wait_idle("simul");

    // Display request every cycle for 10 cycles while an Avalon read waits
    k = cyc;
`ifdef VRAM_FAIRNESS_EN
    avl(0, 12'd599, '0, 4'h0, 32'hCAFEF00D, 7);
`else
    avl(0, 12'd599, '0, 4'h0, 32'hCAFEF00D, 13);
`endif
    for (int i = 0; i < 10; i++) begin
      DISP_REQ = 1'b1; DISP_ADDR = 10'd10;
`ifdef VRAM_FAIRNESS_EN
      if (i == 4) disp_q.push_back('{32'h41424344, k + 8});
      else if (i != 5) disp_q.push_back('{32'h41424344, k + i + 3});
`else
      disp_q.push_back('{32'h41424344, k + i + 3});
`endif
      tick();
    end
    DISP_REQ = 1'b0;
    wait_idle("starve");
    @(negedge CLK);
`ifdef VRAM_FAIRNESS_EN
    check("overrun_fair", 32'(DISP_OVERRUN), 32'd1);
`else
    check("overrun_strict", 32'(DISP_OVERRUN), 32'd0);
`endif
    tick();

    // Reset during the data cycle of an Avalon read, with a display fetch in flight
    avl(0, 12'd10, '0, 4'h0, 32'h41424344, 6);
    tick();
    DISP_REQ = 1'b1; DISP_ADDR = 10'd5;
    tick();
    DISP_REQ = 1'b0; RESET = 1'b1;
    @(negedge CLK);
    check("midrst_waitreq", 32'(AVL_WAITREQUEST), 32'd1);
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    check("midrst_ram_we", 32'(RAM_WE), 32'd0);
    check("midrst_disp_valid", 32'(DISP_VALID), 32'd0);
    check("midrst_rdata", AVL_READDATA, 32'h0);
    check("midrst_ctrl", CTRL_REG, 32'h0);
    check("midrst_ram_addr", 32'(RAM_ADDR), 32'd0);
    check("midrst_overrun", 32'(DISP_OVERRUN), 32'd0);
    wait_idle("retry");

    repeat (4) tick();
    check("disp_q_empty", 32'(disp_q.size()), 32'd0);
    check("avl_q_empty", 32'(avl_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
